// File: rtl/alu_shift_pipe.sv
// Two-stage shift/rotate unit (SLL/SRL/SRA/ROL/ROR, RV64 word mode), valid/ready on both sides.
// Left ops are bit-reversed into right funnel shifts; S1 shifts by the low amount bits, S2 finishes.
module alu_shift_pipe #(
  parameter int XLEN    = 64,
  parameter int TAG_W   = 5,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         in_op,
  input  logic               in_word,
  input  logic [XLEN-1:0]    in_src,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_result,
  output logic [TAG_W-1:0]   out_tag
);
  localparam int LO_W = (SHAMT_W + 1) / 2;
  localparam int HI_W = SHAMT_W - LO_W;

  function automatic logic [XLEN-1:0] f_rev(input logic [XLEN-1:0] a);
    for (int i = 0; i < XLEN; i++) f_rev[i] = a[XLEN-1-i];
  endfunction

  function automatic logic [31:0] f_rev32(input logic [31:0] a);
    for (int i = 0; i < 32; i++) f_rev32[i] = a[31-i];
  endfunction

  logic                r_s1_vld;
  logic [2*XLEN-1:0]   r_s1_f;
  logic [HI_W-1:0]     r_s1_amt_hi;
  logic                r_s1_word;
  logic                r_s1_rev;
  logic                r_s1_rsvd;
  logic [TAG_W-1:0]    r_s1_tag;
  logic                r_s2_vld;
  logic [XLEN-1:0]     r_s2_res;
  logic [TAG_W-1:0]    r_s2_tag;

  logic                w_word, w_rev, w_rot, w_sra, w_rsvd;
  logic [SHAMT_W-1:0]  w_amt;
  logic [31:0]         w_b32;
  logic [XLEN-1:0]     w_base, w_lo, w_hi;
  logic                w_s2_adv, w_acc;
  logic [XLEN-1:0]     w_r, w_res;
  logic [31:0]         w_r32;

  assign w_word = (XLEN == 64) && in_word;
  assign w_rev  = (in_op == 3'd0) || (in_op == 3'd3);
  assign w_rot  = (in_op == 3'd3) || (in_op == 3'd4);
  assign w_sra  = (in_op == 3'd2);
  assign w_rsvd = (in_op > 3'd4);
  assign w_amt  = w_word ? (in_shamt & SHAMT_W'(31)) : in_shamt;

  // Funnel {hi, lo}: hi supplies the bits shifted in from the top (fill or rotate wrap).
  always_comb begin
    w_b32  = w_rev ? f_rev32(in_src[31:0]) : in_src[31:0];
    w_base = w_rev ? f_rev(in_src) : in_src;
    w_lo   = w_base;
    w_hi   = '0;
    if (w_word) begin
      if (w_rot)      w_lo = {(XLEN/32){w_b32}};
      else if (w_sra) w_lo = XLEN'($signed(w_b32));
      else            w_lo = XLEN'(w_b32);
      w_hi = {XLEN{w_sra & in_src[31]}};
    end else if (w_sra) begin
      w_hi = {XLEN{in_src[XLEN-1]}};
    end else if (w_rot) begin
      w_hi = w_base;
    end
  end

  assign w_s2_adv = !r_s2_vld || out_ready;
  assign in_ready = !r_s1_vld || w_s2_adv;
  assign w_acc    = in_valid && in_ready && !flush;

  assign w_r   = XLEN'(r_s1_f >> {r_s1_amt_hi, {LO_W{1'b0}}});
  assign w_r32 = r_s1_rev ? f_rev32(w_r[31:0]) : w_r[31:0];

  always_comb begin
    w_res = r_s1_rev ? f_rev(w_r) : w_r;
    if (r_s1_word) w_res = XLEN'($signed(w_r32));
    if (r_s1_rsvd) w_res = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_vld    <= 1'b0;
      r_s1_f      <= '0;
      r_s1_amt_hi <= '0;
      r_s1_word   <= 1'b0;
      r_s1_rev    <= 1'b0;
      r_s1_rsvd   <= 1'b0;
      r_s1_tag    <= '0;
      r_s2_vld    <= 1'b0;
      r_s2_res    <= '0;
      r_s2_tag    <= '0;
    end else begin
      if (flush)         r_s1_vld <= 1'b0;
      else if (in_ready) r_s1_vld <= in_valid;
      if (w_acc) begin
        r_s1_f      <= {w_hi, w_lo} >> w_amt[LO_W-1:0];
        r_s1_amt_hi <= w_amt[SHAMT_W-1:LO_W];
        r_s1_word   <= w_word;
        r_s1_rev    <= w_rev;
        r_s1_rsvd   <= w_rsvd;
        r_s1_tag    <= in_tag;
      end
      if (flush)         r_s2_vld <= 1'b0;
      else if (w_s2_adv) r_s2_vld <= r_s1_vld;
      if (w_s2_adv && r_s1_vld && !flush) begin
        r_s2_res <= w_res;
        r_s2_tag <= r_s1_tag;
      end
    end
  end

  assign out_valid  = r_s2_vld;
  assign out_result = r_s2_res;
  assign out_tag    = r_s2_tag;
endmodule

// File: tb/tb_alu_shift_pipe.sv
// Bench for alu_shift_pipe: directed plan cases plus random traffic against a queue-based reference.
module tb_alu_shift_pipe;
  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, in_word, out_valid, out_ready;
  logic [2:0]  in_op;
  logic [63:0] in_src, out_result;
  logic [5:0]  in_shamt;
  logic [4:0]  in_tag, out_tag;

  logic        c_in_valid, c_in_ready, c_out_valid;
  logic [2:0]  c_in_op;
  logic [31:0] c_in_src, c_out_result;
  logic [4:0]  c_in_shamt, c_in_tag, c_out_tag;

  always #5 clk = ~clk;

  alu_shift_pipe #(.XLEN(64), .TAG_W(5)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_word(in_word), .in_src(in_src), .in_shamt(in_shamt), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_tag(out_tag));

  alu_shift_pipe #(.XLEN(32), .TAG_W(5)) dut32 (
    .clk(clk), .rst(rst), .flush(1'b0), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_op(c_in_op), .in_word(1'b1), .in_src(c_in_src), .in_shamt(c_in_shamt), .in_tag(c_in_tag),
    .out_valid(c_out_valid), .out_ready(1'b1), .out_result(c_out_result), .out_tag(c_out_tag));

  typedef struct { logic [63:0] res; logic [4:0] tag; int acc; } exp_t;
  exp_t        q[$];
  int          checks = 0, errors = 0, cnt = 0;
  logic [63:0] cur_exp;
  logic        last_acc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref64(input int op, input bit word, input logic [63:0] src, input int sh);
    logic [31:0] x;
    logic [63:0] y;
    int s;
    if (op > 4) return 64'd0;
    if (word) begin
      s = sh & 31;
      x = src[31:0];
      case (op)
        0: x = x << s;
        1: x = x >> s;
        2: x = $signed(x) >>> s;
        3: x = (x << s) | (x >> (32 - s));
        default: x = (x >> s) | (x << (32 - s));
      endcase
      return {{32{x[31]}}, x};
    end
    s = sh & 63;
    y = src;
    case (op)
      0: y = y << s;
      1: y = y >> s;
      2: y = $signed(y) >>> s;
      3: y = (y << s) | (y >> (64 - s));
      default: y = (y >> s) | (y << (64 - s));
    endcase
    return y;
  endfunction

  // Entered and left at posedge+1; checks outputs against the model, then advances one edge.
  task automatic step();
    logic exp_rdy, exp_ov, fire_out, fire_in;
    exp_t e;
    #1;
    exp_rdy = (q.size() < 2) || out_ready;
    chk("in_ready", {63'd0, in_ready}, {63'd0, exp_rdy});
    exp_ov = 1'b0;
    if (q.size() > 0) exp_ov = (cnt >= q[0].acc + 1);
    chk("out_valid", {63'd0, out_valid}, {63'd0, exp_ov});
    if (exp_ov) begin
      chk("out_result", out_result, q[0].res);
      chk("out_tag", {59'd0, out_tag}, {59'd0, q[0].tag});
    end
    fire_out = exp_ov && out_ready;
    fire_in  = in_valid && exp_rdy && !flush;
    if (fire_out) void'(q.pop_front());
    if (flush) q.delete();
    else if (fire_in) begin
      e.res = cur_exp; e.tag = in_tag; e.acc = cnt + 1;
      q.push_back(e);
    end
    last_acc = fire_in;
    @(posedge clk);
    cnt++;
    #1;
  endtask

  task automatic put(input int op, input bit word, input logic [63:0] src, input int sh,
                     input int tag, input logic [63:0] exp);
    in_valid = 1'b1; in_op = op[2:0]; in_word = word; in_src = src;
    in_shamt = sh[5:0]; in_tag = tag[4:0]; cur_exp = exp;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_op = '0; in_word = 1'b0; in_src = '0;
    in_shamt = '0; in_tag = '0; out_ready = 1'b1; cur_exp = '0; last_acc = 1'b0;
    c_in_valid = 1'b0; c_in_op = '0; c_in_src = '0; c_in_shamt = '0; c_in_tag = '0;
    #1;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_result", out_result, 64'd0);
    chk("rst_out_tag", {59'd0, out_tag}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk); cnt++;
    #3 rst = 1'b0;
    @(posedge clk); cnt++;
    #1;

    // Back-to-back full-width ops
    put(0, 0, 64'h3, 63, 1, 64'h8000_0000_0000_0000); step();
    put(2, 0, 64'h8000_0000_0000_0000, 4, 2, 64'hF800_0000_0000_0000); step();
    put(4, 0, 64'h1, 1, 3, 64'h8000_0000_0000_0000); step();
    idle(4);

    // Word mode, shift by zero, reserved op
    put(2, 1, 64'h0000_0000_8000_0000, 4, 4, 64'hFFFF_FFFF_F800_0000); step();
    put(1, 1, 64'hFFFF_FFFF_8000_0000, 4, 5, 64'h0000_0000_0800_0000); step();
    put(0, 1, 64'h1, 37, 6, 64'h20); step();
    put(4, 1, 64'h1, 1, 7, 64'hFFFF_FFFF_8000_0000); step();
    put(1, 0, 64'hDEAD_BEEF_0000_0001, 0, 8, 64'hDEAD_BEEF_0000_0001); step();
    put(1, 1, 64'h0000_0000_8000_0000, 0, 9, 64'hFFFF_FFFF_8000_0000); step();
    put(6, 0, 64'h1234_5678_9ABC_DEF0, 5, 10, 64'h0); step();
    idle(4);

    // Backpressure: A, B accepted, C stalls until out_ready rises
    out_ready = 1'b0;
    put(3, 0, 64'h8000_0000_0000_0001, 1, 11, 64'h3); step();
    put(1, 0, 64'hF0, 4, 12, 64'hF); step();
    put(0, 0, 64'h1, 8, 13, 64'h100); step();
    step();
    chk("bp_c_held", {63'd0, last_acc}, 64'd0);
    step();
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    idle(4);

    // Flush with A in S2, B in S1, C offered
    out_ready = 1'b0;
    put(0, 0, 64'h5, 1, 14, 64'hA); step();
    put(0, 0, 64'h5, 2, 15, 64'h14); step();
    put(0, 0, 64'h5, 3, 16, 64'h28); flush = 1'b1; step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step();
    put(1, 0, 64'h100, 8, 17, 64'h1); step();
    idle(4);

    // Async reset with two ops in flight
    out_ready = 1'b0;
    put(0, 0, 64'h7, 4, 18, 64'h70); step();
    put(0, 0, 64'h7, 5, 19, 64'hE0); step();
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("arst_out_result", out_result, 64'd0);
    chk("arst_out_tag", {59'd0, out_tag}, 64'd0);
    chk("arst_in_ready", {63'd0, in_ready}, 64'd1);
    q.delete();
    @(posedge clk); cnt++;
    #3 rst = 1'b0;
    @(posedge clk); cnt++;
    #1;
    out_ready = 1'b1;
    put(3, 1, 64'h8000_0001, 4, 20, 64'h18); step();
    idle(4);

    // Random traffic
    for (int it = 0; it < 600; it++) begin
      int op, sh;
      bit wd;
      logic [63:0] src;
      op  = $urandom_range(0, 7);
      wd  = $urandom_range(0, 1);
      sh  = $urandom_range(0, 63);
      src = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) src = {{32{src[31]}}, src[31:0]};
      put(op, wd, src, sh, $urandom_range(0, 31), ref64(op, wd, src, sh));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      step();
    end
    flush = 1'b0; out_ready = 1'b1;
    idle(6);

    // 32-bit build: SRA 0x8000_0000 by 31
    c_in_valid = 1'b1; c_in_op = 3'd2; c_in_src = 32'h8000_0000; c_in_shamt = 5'd31; c_in_tag = 5'd21;
    #1;
    chk("x32_in_ready", {63'd0, c_in_ready}, 64'd1);
    @(posedge clk); cnt++;
    #1;
    c_in_valid = 1'b0;
    chk("x32_lat_valid", {63'd0, c_out_valid}, 64'd0);
    @(posedge clk); cnt++;
    #1;
    chk("x32_out_valid", {63'd0, c_out_valid}, 64'd1);
    chk("x32_out_result", {32'd0, c_out_result}, 64'hFFFF_FFFF);
    chk("x32_out_tag", {59'd0, c_out_tag}, 64'd21);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
